// File: rtl/opll_bus_pkg.sv
// Shared types and chip timing constants for the OPLL CPU-port bus writer.
package opll_bus_pkg;

    // Bus sequencer states, one per phase of the two-step OPLL write.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_A_SET = 3'd1,
        ST_A_STB = 3'd2,
        ST_A_GAP = 3'd3,
        ST_D_SET = 3'd4,
        ST_D_STB = 3'd5,
        ST_D_GAP = 3'd6
    } opll_state_e;

    // Minimum strobe width and post-write wait times the OPLL needs.
    localparam int OPLL_WR_PULSE  = 4;
    localparam int OPLL_ADDR_WAIT = 12;
    localparam int OPLL_DATA_WAIT = 84;

    // Largest of three durations; sets the width of the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/opll_cmd_fifo.sv
// Synchronous command FIFO holding {addr, data} pairs. Read data is the
// current head (first-word fall-through), so a pop and its data are in the
// same cycle. Full/empty decode only registered state, so the ready the
// host sees never depends on a pop in the same cycle.
module opll_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/opll_bus_writer.sv
// Replays queued {addr, data} commands onto the OPLL CPU port as an address
// write (A0=0) followed by a data write (A0=1), holding the strobe and the
// post-write waits the chip needs.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | nothing in flight, waiting for a queued command
// A_SET    | address on bus, A0=0, one cycle of setup before strobe
// A_STB    | address strobe high for WR_PULSE cycles
// A_GAP    | ADDR_WAIT idle cycles, address still driven
// D_SET    | data on bus, A0=1, one cycle of setup before strobe
// D_STB    | data strobe high for WR_PULSE cycles
// D_GAP    | DATA_WAIT idle cycles, then next command or IDLE
module opll_bus_writer
    import opll_bus_pkg::*;
#(
    parameter int WR_PULSE   = OPLL_WR_PULSE,
    parameter int ADDR_WAIT  = OPLL_ADDR_WAIT,
    parameter int DATA_WAIT  = OPLL_DATA_WAIT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [7:0]                    i_addr,
    input  logic [7:0]                    i_data,
    output logic [7:0]                    o_d,
    output logic                          o_a0,
    output logic                          o_wr,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int CNT_W = $clog2(max3(WR_PULSE, ADDR_WAIT, DATA_WAIT) + 1);
    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] AGAP_LOAD = CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] DGAP_LOAD = CNT_W'(DATA_WAIT - 1);

    opll_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, data_q;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [15:0]      fifo_rdata;

    opll_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_valid),
        .wdata_i ({i_addr, i_data}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (o_level)
    );

    assign o_ready = ~fifo_full;
    assign o_busy  = (state_q != ST_IDLE) | ~fifo_empty;
    assign o_wr    = (state_q == ST_A_STB) | (state_q == ST_D_STB);
    assign o_a0    = (state_q == ST_D_SET) | (state_q == ST_D_STB) | (state_q == ST_D_GAP);
    // Bus data only switches in the SET states, where the strobe is low.
    assign o_d     = o_a0 ? data_q : addr_q;

    // State, phase counter and the popped command's holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                addr_q <= fifo_rdata[15:8];
                data_q <= fifo_rdata[7:0];
            end
        end
    end

    // Next state: each phase ends when the counter loaded on entry reaches 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_A_SET;
                    cnt_d   = '0;
                end
            end
            ST_A_SET: begin
                if (cnt_q == '0) begin
                    state_d = ST_A_STB;
                    cnt_d   = WR_LOAD;
                end
            end
            ST_A_STB: begin
                if (cnt_q == '0) begin
                    state_d = ST_A_GAP;
                    cnt_d   = AGAP_LOAD;
                end
            end
            ST_A_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_D_SET;
                    cnt_d   = '0;
                end
            end
            ST_D_SET: begin
                if (cnt_q == '0) begin
                    state_d = ST_D_STB;
                    cnt_d   = WR_LOAD;
                end
            end
            ST_D_STB: begin
                if (cnt_q == '0) begin
                    state_d = ST_D_GAP;
                    cnt_d   = DGAP_LOAD;
                end
            end
            ST_D_GAP: begin
                if (cnt_q == '0) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_A_SET;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_opll_bus_writer.sv
module tb_opll_bus_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] ai0 = 8'h00, di0 = 8'h00, ai1 = 8'h00, di1 = 8'h00;

    logic       rdy0, a00, wr0, busy0, rdy1, a01, wr1, busy1;
    logic [7:0] d0, d1;
    logic [2:0] lvl0, lvl1;

    opll_bus_writer u_dut0 (
        .clk(clk), .rst(rst), .i_valid(v0), .o_ready(rdy0),
        .i_addr(ai0), .i_data(di0), .o_d(d0), .o_a0(a00), .o_wr(wr0),
        .o_busy(busy0), .o_level(lvl0)
    );

    opll_bus_writer #(.WR_PULSE(1), .ADDR_WAIT(1), .DATA_WAIT(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .o_ready(rdy1),
        .i_addr(ai1), .i_data(di1), .o_d(d1), .o_a0(a01), .o_wr(wr1),
        .o_busy(busy1), .o_level(lvl1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each DUT: queue of pending commands, and the offset t into the
    // current command's fixed-length bus waveform.
    logic [15:0] mq [2][8];
    int          mcnt [2];
    bit          mact [2];
    int          mt   [2];
    logic [15:0] mcur [2];

    function automatic int pw(input int k); return (k == 0) ? 4  : 1; endfunction
    function automatic int aw(input int k); return (k == 0) ? 12 : 1; endfunction
    function automatic int dw(input int k); return (k == 0) ? 84 : 1; endfunction
    function automatic int period(input int k); return 2 + 2*pw(k) + aw(k) + dw(k); endfunction

    task automatic mpop(input int k);
        mcur[k] = mq[k][0];
        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
        mcnt[k]--;
        mact[k] = 1'b1;
        mt[k]   = 0;
    endtask

    task automatic model_step(input int k, input logic r, input logic v, input logic [15:0] cmd);
        int pre;
        if (r) begin
            mcnt[k] = 0; mact[k] = 1'b0; mt[k] = 0;
        end else begin
            pre = mcnt[k];
            if (mact[k]) begin
                if (mt[k] == period(k) - 1) begin
                    if (pre > 0) mpop(k);
                    else mact[k] = 1'b0;
                end else begin
                    mt[k]++;
                end
            end else if (pre > 0) begin
                mpop(k);
            end
            if (v && pre < 4) begin
                mq[k][mcnt[k]] = cmd;
                mcnt[k]++;
            end
        end
    endtask

    // Expected bus pins at offset t of a command.
    task automatic exp_bus(input int k, output int e_wr, output int e_a0, output int e_d);
        int t, w, a;
        t = mt[k]; w = pw(k); a = aw(k);
        e_wr = ((t >= 1 && t <= w) || (t >= w + a + 2 && t <= 2*w + a + 1)) ? 1 : 0;
        e_a0 = (t >= w + a + 1) ? 1 : 0;
        e_d  = e_a0 ? int'(mcur[k][7:0]) : int'(mcur[k][15:8]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin mcnt[k] = 0; mact[k] = 1'b0; mt[k] = 0; mcur[k] = '0; end
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, rst, v0, {ai0, di0});
            model_step(1, rst, v1, {ai1, di1});
        end
    end

    // Compare process: every cycle once reset has been applied.
    initial begin
        int e_wr, e_a0, e_d;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_bus(0, e_wr, e_a0, e_d);
                check("dut0 o_wr",    int'(wr0),   mact[0] ? e_wr : 0);
                check("dut0 o_ready", int'(rdy0),  (mcnt[0] < 4) ? 1 : 0);
                check("dut0 o_busy",  int'(busy0), (mact[0] || mcnt[0] > 0) ? 1 : 0);
                check("dut0 o_level", int'(lvl0),  mcnt[0]);
                if (mact[0]) begin
                    check("dut0 o_a0", int'(a00), e_a0);
                    check("dut0 o_d",  int'(d0),  e_d);
                end
                exp_bus(1, e_wr, e_a0, e_d);
                check("dut1 o_wr",    int'(wr1),   mact[1] ? e_wr : 0);
                check("dut1 o_ready", int'(rdy1),  (mcnt[1] < 4) ? 1 : 0);
                check("dut1 o_busy",  int'(busy1), (mact[1] || mcnt[1] > 0) ? 1 : 0);
                check("dut1 o_level", int'(lvl1),  mcnt[1]);
                if (mact[1]) begin
                    check("dut1 o_a0", int'(a01), e_a0);
                    check("dut1 o_d",  int'(d1),  e_d);
                end
            end
        end
    end

    // Address-strobe rise times and strobe-window bus stability.
    int   rise0 [64];
    int   rise1 [64];
    int   nr0 = 0, nr1 = 0, unstab = 0;
    logic pwr0 = 1'b0, pwr1 = 1'b0;
    logic [7:0] pd1 = 8'h00;
    logic pa1 = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (wr0 && !pwr0 && !a00 && nr0 < 64) begin rise0[nr0] = cyc; nr0++; end
            if (wr1 && !pwr1 && !a01 && nr1 < 64) begin rise1[nr1] = cyc; nr1++; end
            if (wr1 && (d1 !== pd1 || a01 !== pa1)) unstab++;
            pwr0 = wr0; pwr1 = wr1; pd1 = d1; pa1 = a01;
        end
    end

    task automatic tick(); @(negedge clk); endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int tp, first, nwr, acc, base, base1, unst0, found;

        // Reset held three cycles.
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset o_wr",    int'(wr0),   0);
        check("reset o_a0",    int'(a00),   0);
        check("reset o_d",     int'(d0),    0);
        check("reset o_ready", int'(rdy0),  1);
        check("reset o_busy",  int'(busy0), 0);
        check("reset o_level", int'(lvl0),  0);
        rst = 1'b0;
        tick();

        // Single command 0x10 <- 0x5A.
        ai0 = 8'h10; di0 = 8'h5A; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tp = cyc;
        check("single level after push", int'(lvl0), 1);
        first = -1; nwr = 0;
        for (int i = 0; i < 200 && busy0; i++) begin
            if (wr0) begin
                nwr++;
                if (first < 0) first = cyc;
            end
            tick();
        end
        check("single first strobe latency", first - tp, 2);
        check("single strobe cycles", nwr, 8);
        check("single busy fall", cyc - tp, 107);
        check("single busy low", int'(busy0), 0);

        // Burst: six consecutive offers into a 4-deep FIFO.
        tick();
        base = nr0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (rdy0) acc++;
            v0 = 1'b1; ai0 = 8'h20 + 8'(i); di0 = 8'hA0 + 8'(i);
            tick();
        end
        v0 = 1'b0;
        check("burst accepted", acc, 5);
        check("burst ready after full", int'(rdy0), 0);
        check("burst level", int'(lvl0), 4);
        for (int i = 0; i < 700 && busy0; i++) tick();
        check("burst drained", int'(busy0), 0);
        tick();
        check("burst commands emitted", nr0 - base, 5);
        for (int i = 0; i < 4; i++)
            check("burst spacing", rise0[base+i+1] - rise0[base+i], 106);

        // Reset during the data strobe with two commands queued.
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; ai0 = 8'h30 + 8'(i); di0 = 8'h50 + 8'(i);
            tick();
        end
        v0 = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (wr0 && a00) found = 1;
            else tick();
        end
        check("reached data strobe", found, 1);
        check("queued before reset", int'(lvl0), 2);
        rst = 1'b1;
        tick();
        check("mid reset o_wr", int'(wr0), 0);
        check("mid reset o_level", int'(lvl0), 0);
        check("mid reset o_busy", int'(busy0), 0);
        rst = 1'b0;
        nwr = 0;
        repeat (300) begin
            if (wr0) nwr++;
            tick();
        end
        check("discarded commands never emitted", nwr, 0);

        // Minimum timing instance: two queued commands.
        base1 = nr1; unst0 = unstab;
        v1 = 1'b1; ai1 = 8'h40; di1 = 8'h11;
        tick();
        ai1 = 8'h41; di1 = 8'h22;
        tick();
        v1 = 1'b0;
        for (int i = 0; i < 100 && busy1; i++) tick();
        check("min busy drained", int'(busy1), 0);
        tick();
        check("min commands emitted", nr1 - base1, 2);
        check("min command period", rise1[base1+1] - rise1[base1], 6);
        check("min bus stable under strobe", unstab - unst0, 0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
